dec_count_ctrl: RTL

DEC_COUNT_CTRL -- requirements
Module: dec_count_ctrl

---
 rtl/dec_count_pkg.sv | 9 +
 rtl/bcd_digit.sv | 15 +
 rtl/dec_count_ctrl.sv | 51 +++++
 3 files changed

// File: rtl/dec_count_pkg.sv
// dec_count_pkg: state encoding, BCD constants and target validity check
package dec_count_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2, DONE = 2'd3;
  function automatic logic bcd_ok(input logic [7:0] v);
    return v[7:4] <= BCD_MAX && v[3:0] <= BCD_MAX;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one decade counter digit with synchronous clear/zero and ripple carry
module bcd_digit
  import dec_count_pkg::*;
(
  input  logic             clock,
  input  logic             clear,
  input  logic             zero,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);
  assign carry = inc && q == BCD_MAX;
  always_ff @(posedge clock)
    q <= clear || zero ? '0 : inc ? (carry ? '0 : q + 1'b1) : q;
endmodule

// File: rtl/dec_count_ctrl.sv
// dec_count_ctrl: prescaled two-digit BCD up-counter run to a latched terminal count
module dec_count_ctrl
  import dec_count_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       start,
  input  logic       hold,
  input  logic [7:0] target,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       step,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  logic [1:0] state;
  logic [PW-1:0] pre;
  logic [7:0] tgt, nxt;
  logic idle_like, go, adv, hit, ones_c, tens_c;
  assign idle_like = state == IDLE || state == DONE;
  assign go = idle_like && start && bcd_ok(target);
  assign adv = state == RUN && !hold && pre == PMAX;
  assign nxt = {tens_c ? 4'd0 : tens + {3'd0, ones_c}, ones_c ? 4'd0 : ones + 4'd1};
  assign hit = adv && nxt == tgt;
  assign busy = state == RUN || state == HOLD;
  assign done = state == DONE;
  bcd_digit u_ones (.clock(clock), .clear(clear), .zero(go), .inc(adv), .q(ones), .carry(ones_c));
  bcd_digit u_tens (.clock(clock), .clear(clear), .zero(go), .inc(ones_c), .q(tens), .carry(tens_c));
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      pre <= '0;
      tgt <= '0;
      step <= 1'b0;
      err <= 1'b0;
    end else begin
      step <= adv;
      err <= idle_like && start && !bcd_ok(target);
      tgt <= go ? target : tgt;
      pre <= go ? '0 : state == RUN && !hold ? (adv ? '0 : pre + 1'b1) : pre;
      state <= go ? (target == 8'h00 ? DONE : RUN)
             : state == RUN ? (hold ? HOLD : hit ? DONE : RUN)
             : state == HOLD ? (hold ? HOLD : RUN) : state;
    end
  end
endmodule
